fetch_sequencer: RTL

//  Owns the PC register and IF/ID register of the P5 pipeline. It issues one outstanding

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: the FSM state codes,
// the default reset PC and a small PC increment helper.
package fetch_sequencer_pkg;

  // Two-bit state codes used by the fetch FSM
  localparam logic [1:0] FS_RESET = 2'd0;
  localparam logic [1:0] FS_FETCH = 2'd1;
  localparam logic [1:0] FS_HOLD  = 2'd2;

  // First fetch address after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_RESET = FS_RESET,
    S_FETCH = FS_FETCH,
    S_HOLD  = FS_HOLD
  } fs_state_t;

  // Sequential next PC; wraps modulo 2^32 and keeps the low two bits untouched
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the PC and the IF/ID register. Issues a single outstanding fetch to a
// variable-latency imem, parks a returned instruction in a one-entry skid
// register while decode is stalled, and applies redirects with delay-slot
// semantics (the fetch already in flight is always delivered first).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_pc4,
  output logic [31:0] f_instr
);

  fs_state_t   state_reg;
  fs_state_t   state_next;
  logic [31:0] pc_reg;
  logic        pend_valid_reg;
  logic [31:0] pend_pc_reg;
  logic [31:0] skid_reg;

  logic        slot_free;
  logic        consume;
  logic        accept;
  logic        ack_ok;
  logic        deliver;
  logic [31:0] deliver_data;
  logic [31:0] pc_next;

  // The IF/ID slot can take a new instruction when empty or being consumed.
  // A redirect is accepted only when its instruction is actually consumed,
  // so a redirect held through a stall is applied exactly once.
  assign slot_free = !f_valid || !stall;
  assign consume   = f_valid && !stall;
  assign accept    = redirect_valid && consume;
  assign ack_ok    = imem_req && imem_ack;

  assign deliver = ((state_reg == S_FETCH) && ack_ok && slot_free) ||
                   ((state_reg == S_HOLD) && slot_free);
  assign deliver_data = (state_reg == S_HOLD) ? skid_reg : imem_rdata;

  assign imem_addr = pc_reg;
  assign f_pc4     = pc_plus4(f_pc);

  // Next fetch address: a fresh redirect beats a parked one, which beats pc+4
  always_comb begin
    pc_next = pc_plus4(pc_reg);
    if (accept) begin
      pc_next = redirect_pc;
    end else if (pend_valid_reg) begin
      pc_next = pend_pc_reg;
    end
  end

  // FSM transitions: reset idles one cycle, fetch until ack, hold while the slot is busy
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH: if (ack_ok && !slot_free) state_next = S_HOLD;
      S_HOLD:  if (slot_free) state_next = S_FETCH;
      default: state_next = S_RESET;
    endcase
  end

  // State, PC, pending redirect, skid and IF/ID register updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_RESET;
      pc_reg         <= RESET_PC;
      pend_valid_reg <= 1'b0;
      pend_pc_reg    <= 32'd0;
      skid_reg       <= 32'd0;
      imem_req       <= 1'b0;
      f_valid        <= 1'b0;
      f_pc           <= 32'd0;
      f_instr        <= 32'd0;
    end else begin
      state_reg <= state_next;
      imem_req  <= (state_next == S_FETCH);
      if ((state_reg == S_FETCH) && ack_ok && !slot_free) begin
        skid_reg <= imem_rdata;
      end
      if (deliver) begin
        f_pc           <= pc_reg;
        f_instr        <= deliver_data;
        f_valid        <= 1'b1;
        pc_reg         <= pc_next;
        pend_valid_reg <= 1'b0;
      end else begin
        if (consume) begin
          f_valid <= 1'b0;
        end
        if (accept) begin
          pend_valid_reg <= 1'b1;
          pend_pc_reg    <= redirect_pc;
        end
      end
    end
  end

endmodule
